// File: rtl/mario_pkg.sv
// rtl/mario_pkg.sv - shared Mario state codes, board bounds and sprite geometry
package mario_pkg;

  typedef enum logic [2:0] {
    ST_INITIAL  = 3'b000,
    ST_FLYING   = 3'b001,
    ST_JUMPING  = 3'b010,
    ST_WALKING  = 3'b011,
    ST_STANDING = 3'b100,
    ST_DYING    = 3'b101,
    ST_CLAMPING = 3'b110
  } mario_state_t;

  localparam int SCREEN_RIGHT  = 590;
  localparam int SCREEN_BOTTOM = 430;
  localparam int SPRITE_W      = 34;
  localparam int SPRITE_H      = 36;

  localparam int X_LEFT   = 50;
  localparam int X_RIGHT  = SCREEN_RIGHT - SPRITE_W;
  localparam int Y_TOP    = 50;
  localparam int Y_GROUND = SCREEN_BOTTOM - SPRITE_H;
  localparam int X_START  = 100;

  // Saturate a widened x candidate back into the playable column range.
  function automatic logic [9:0] clamp_x(input logic signed [11:0] x);
    if (x < 12'(X_LEFT))
      return 10'(X_LEFT);
    else if (x > 12'(X_RIGHT))
      return 10'(X_RIGHT);
    else
      return x[9:0];
  endfunction

endpackage

// File: rtl/mario_vphys.sv
// rtl/mario_vphys.sv - vertical velocity/position integrator with ceiling and ground clamp
module mario_vphys
  import mario_pkg::*;
#(
  parameter int JUMP_V  = 12,
  parameter int GRAVITY = 1,
  parameter int VMAX    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              restore,
  input  logic              kick,
  output logic [8:0]        pos_y,
  output logic              grounded,
  output logic signed [5:0] vy_int,
  output logic              grounded_int
);

  logic signed [5:0]  vy_q;
  logic signed [5:0]  vy_eff;
  logic signed [5:0]  vy_d;
  logic [8:0]         y_q;
  logic [8:0]         y_d;
  logic               g_q;
  logic               g_d;
  logic signed [10:0] y_sum;
  logic signed [6:0]  vy_grav;

  always_comb begin
    vy_eff  = kick ? 6'(-JUMP_V) : vy_q;
    y_sum   = signed'({2'b00, y_q}) + 11'(vy_eff);
    vy_grav = 7'(vy_eff) + 7'(GRAVITY);
    y_d     = y_sum[8:0];
    vy_d    = (vy_grav > 7'(VMAX)) ? 6'(VMAX) : vy_grav[5:0];
    g_d     = 1'b0;
    if (y_sum >= 11'(Y_GROUND)) begin
      y_d  = 9'(Y_GROUND);
      vy_d = '0;
      g_d  = 1'b1;
    end else if (y_sum < 11'(Y_TOP)) begin
      // Ceiling bump kills upward speed; gravity resumes next frame.
      y_d  = 9'(Y_TOP);
      vy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q  <= 9'(Y_GROUND);
      vy_q <= '0;
      g_q  <= 1'b1;
    end else if (restore) begin
      y_q  <= 9'(Y_GROUND);
      vy_q <= '0;
      g_q  <= 1'b1;
    end else if (step) begin
      y_q  <= y_d;
      vy_q <= vy_d;
      g_q  <= g_d;
    end
  end

  assign pos_y        = y_q;
  assign grounded     = g_q;
  assign vy_int       = vy_d;
  assign grounded_int = g_d;

endmodule

// File: rtl/mario_motion.sv
// rtl/mario_motion.sv - frame-stepped Mario motion/state FSM; MARIO_DOUBLE_JUMP_EN enables one air jump
module mario_motion
  import mario_pkg::*;
#(
  parameter int STEP_X       = 2,
  parameter int JUMP_V       = 12,
  parameter int GRAVITY      = 1,
  parameter int VMAX         = 8,
  parameter int DEATH_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       hit,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic [2:0] state
);

  localparam int CW = $clog2(DEATH_FRAMES + 1);

  mario_state_t      state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              jump_prev_q;
  logic              hit_latch_q;
  logic              step, restore, kick;
  logic              grounded, grounded_int;
  logic signed [5:0] vy_int;
  logic              jump_edge, hit_eff, left_only, right_only;
  logic signed [11:0] x_wide, x_step;
  logic              air_jump_ok;
  logic              air_jump_used;
  logic              air_rearm;

  mario_vphys #(
    .JUMP_V  (JUMP_V),
    .GRAVITY (GRAVITY),
    .VMAX    (VMAX)
  ) u_vphys (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         (step),
    .restore      (restore),
    .kick         (kick),
    .pos_y        (posY),
    .grounded     (grounded),
    .vy_int       (vy_int),
    .grounded_int (grounded_int)
  );

  assign jump_edge  = btn_jump & ~jump_prev_q;
  assign hit_eff    = hit | hit_latch_q;
  assign left_only  = btn_left & ~btn_right;
  assign right_only = btn_right & ~btn_left;
  assign x_wide     = signed'({2'b00, x_q});
  assign x_step     = 12'(STEP_X);

`ifdef MARIO_DOUBLE_JUMP_EN
  logic air_avail_q;

  assign air_jump_ok = air_avail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      air_avail_q <= 1'b1;
    else if (air_rearm)
      air_avail_q <= 1'b1;
    else if (air_jump_used)
      air_avail_q <= 1'b0;
  end
`else
  assign air_jump_ok = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    cnt_d         = cnt_q;
    step          = 1'b0;
    restore       = 1'b0;
    kick          = 1'b0;
    air_jump_used = 1'b0;
    air_rearm     = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        ST_INITIAL: begin
          if (btn_left | btn_right | btn_jump)
            state_d = ST_STANDING;
        end
        ST_DYING: begin
          if (cnt_q == CW'(DEATH_FRAMES - 1)) begin
            state_d   = ST_INITIAL;
            x_d       = 10'(X_START);
            cnt_d     = '0;
            restore   = 1'b1;
            air_rearm = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          if (hit_eff) begin
            // Freeze in place; hit outranks any move or jump this frame.
            state_d = ST_DYING;
            cnt_d   = '0;
          end else begin
            if (left_only)
              x_d = clamp_x(x_wide - x_step);
            else if (right_only)
              x_d = clamp_x(x_wide + x_step);
            step = 1'b1;
            if (jump_edge && grounded) begin
              kick = 1'b1;
            end else if (jump_edge && air_jump_ok) begin
              kick          = 1'b1;
              air_jump_used = 1'b1;
            end
            if (grounded_int) begin
              air_rearm = 1'b1;
              if ((left_only && x_d == 10'(X_LEFT)) || (right_only && x_d == 10'(X_RIGHT)))
                state_d = ST_CLAMPING;
              else if (left_only || right_only)
                state_d = ST_WALKING;
              else
                state_d = ST_STANDING;
            end else begin
              state_d = (vy_int < 0) ? ST_JUMPING : ST_FLYING;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INITIAL;
      x_q         <= 10'(X_START);
      cnt_q       <= '0;
      jump_prev_q <= 1'b0;
    end else if (frame_tick) begin
      state_q     <= state_d;
      x_q         <= x_d;
      cnt_q       <= cnt_d;
      jump_prev_q <= btn_jump;
    end
  end

  // Contact can arrive on any cycle; hold it until the frame that consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hit_latch_q <= 1'b0;
    else if (frame_tick)
      hit_latch_q <= 1'b0;
    else if (hit)
      hit_latch_q <= 1'b1;
  end

  assign posX  = x_q;
  assign state = state_q;

endmodule

// File: tb/tb_mario_motion.sv
// tb/tb_mario_motion.sv - directed self-checking bench for mario_motion
module tb_mario_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_jump = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] posX;
  logic [8:0] posY;
  logic [2:0] state;

  int tests = 0;
  int failed = 0;

  localparam int S_INITIAL = 0, S_FLYING = 1, S_JUMPING = 2, S_WALKING = 3;
  localparam int S_STANDING = 4, S_DYING = 5, S_CLAMPING = 6;

  mario_motion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .hit        (hit),
    .posX       (posX),
    .posY       (posY),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int s, input int x, input int y);
    check({tag, ".state"}, int'(state), s);
    check({tag, ".posX"}, int'(posX), x);
    check({tag, ".posY"}, int'(posY), y);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all("reset", S_INITIAL, 100, 394);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start, then walk right
    btn_right = 1'b1;
    tick();
    check_all("start", S_STANDING, 100, 394);
    tick();
    check_all("walk_r", S_WALKING, 102, 394);
    btn_right = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_no_tick.posX", int'(posX), 102);

    // Walk left into the wall
    btn_left = 1'b1;
    tick();
    check_all("walk_l", S_WALKING, 100, 394);
    ticks(39);
    check_all("clamp_l", S_CLAMPING, 50, 394);
    btn_left = 1'b0;
    tick();
    check_all("idle", S_STANDING, 50, 394);

    // Full jump arc with jump held
    btn_jump = 1'b1;
    tick();
    check_all("jump1", S_JUMPING, 50, 382);
    tick();
    check("jump2.posY", int'(posY), 371);
    tick();
    check("jump3.posY", int'(posY), 361);
    ticks(8);
    check_all("jump11", S_JUMPING, 50, 317);
    tick();
    check_all("apex", S_FLYING, 50, 316);
    ticks(14);
    check_all("fall26", S_FLYING, 50, 392);
    tick();
    check_all("land", S_STANDING, 50, 394);
    btn_jump = 1'b0;
    tick();
    check_all("post_land", S_STANDING, 50, 394);

    // Second jump edge in the air
    btn_jump = 1'b1;
    tick();
    check("dj1.posY", int'(posY), 382);
    btn_jump = 1'b0;
    tick();
    check("dj2.posY", int'(posY), 371);
    btn_jump = 1'b1;
    tick();
`ifdef MARIO_DOUBLE_JUMP_EN
    check("dj3.posY", int'(posY), 359);
    tick();
    check("dj4.posY", int'(posY), 348);
`else
    check("dj3.posY", int'(posY), 361);
    tick();
    check("dj4.posY", int'(posY), 352);
`endif
    check("dj4.state", int'(state), S_JUMPING);
    btn_jump = 1'b0;

    // Hit pulse between ticks, latched until the next frame
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    repeat (3) @(negedge clk);
`ifdef MARIO_DOUBLE_JUMP_EN
    tick();
    check_all("die", S_DYING, 50, 348);
    btn_right = 1'b1;
    ticks(10);
    hit = 1'b1;
    tick();
    hit = 1'b0;
    ticks(20);
    check_all("dying31", S_DYING, 50, 348);
`else
    tick();
    check_all("die", S_DYING, 50, 352);
    btn_right = 1'b1;
    ticks(10);
    hit = 1'b1;
    tick();
    hit = 1'b0;
    ticks(20);
    check_all("dying31", S_DYING, 50, 352);
`endif
    btn_right = 1'b0;
    tick();
    check_all("respawn", S_INITIAL, 100, 394);
    tick();
    check_all("initial_idle", S_INITIAL, 100, 394);

    // Async reset while flying
    btn_jump = 1'b1;
    tick();
    check("restart.state", int'(state), S_STANDING);
    btn_jump = 1'b0;
    tick();
    btn_jump = 1'b1;
    btn_right = 1'b1;
    ticks(12);
    check_all("fly_pre_rst", S_FLYING, 124, 316);
    btn_jump = 1'b0;
    btn_right = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", S_INITIAL, 100, 394);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("after_rst", S_INITIAL, 100, 394);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mario_motion.md
MARIO_MOTION -- requirements
Module: mario_motion

Interface
REQ-001 SHALL have parameter STEP_X, default 2, horizontal pixels moved per frame.
REQ-002 SHALL have parameter JUMP_V, default 12, initial upward speed in px/frame.
REQ-003 SHALL have parameter GRAVITY, default 1, downward speed added each frame.
REQ-004 SHALL have parameter VMAX, default 8, maximum fall speed.
REQ-005 SHALL have parameter DEATH_FRAMES, default 32, number of frames spent in DYING.
REQ-006 SHALL have port clk, input, 1, sole clock; one clock, reset is asynchronous and active-low.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-009 SHALL have ports btn_left, btn_right, btn_jump, input, 1 each, synchronised level buttons.
REQ-010 SHALL have port hit, input, 1, enemy-contact pulse.
REQ-011 SHALL have port posX, output, 10, sprite top-left x.
REQ-012 SHALL have port posY, output, 9, sprite top-left y.
REQ-013 SHALL have port state, output, 3, Mario state code consumed by the sprite/debug renderer.

Function
REQ-014 SHALL update all registers only on clk edges where frame_tick=1, and hold every output otherwise; new values are visible the cycle after the tick.
REQ-015 SHALL use these state codes: INITIAL 000, FLYING 001, JUMPING 010, WALKING 011, STANDING 100, DYING 101, CLAMPING 110.
REQ-016 SHALL use these bounds: X range [LEFT 50, RIGHT 590-34=556]; Y range [TOP 50, GROUND 430-36=394].
REQ-017 SHALL, in INITIAL, hold posX=100 and posY=394, and go to STANDING on the first tick with any button high.
REQ-018 SHALL apply horizontal motion at each tick: left only gives posX-=STEP_X, right only gives posX+=STEP_X, both or neither gives no change; the result SHALL be clamped to [50,556] with no wrap-around.
REQ-019 SHALL keep a signed 6-bit vertical velocity vy; on a tick: posY+=vy, then vy=min(vy+GRAVITY, VMAX) while airborne.
REQ-020 SHALL detect a jump as btn_jump high at this tick and low at the previous tick; when grounded, a jump sets vy=-JUMP_V and the state goes to JUMPING.
REQ-021 SHALL, if posY+vy<50, set posY=50 and vy=0 (ceiling bump).
REQ-022 SHALL, if posY+vy>=394, set posY=394 and vy=0, and land.
REQ-023 SHALL, when airborne, report JUMPING if vy<0 and FLYING if vy>=0.
REQ-024 SHALL, when grounded and not dying, report CLAMPING if posX sits at a bound and the pushing button points into that bound; else WALKING if exactly one of left/right is high; else STANDING.
REQ-025 SHALL, on hit (sampled any cycle and latched until the next tick), enter DYING with posX/posY frozen; hit takes priority over jump and move.
REQ-026 SHALL leave DYING after DEATH_FRAMES ticks, going to INITIAL with positions restored; hit during DYING SHALL not restart the count.

Reset
REQ-027 SHALL, on rst_n=0 (asynchronously, any time, including mid-jump or mid-death), force state=INITIAL, posX=100, posY=394, vy=0, death counter=0, hit latch=0 and jump-edge history=0.

Configuration
REQ-028 SHALL, with MARIO_DOUBLE_JUMP_EN defined, allow one extra jump edge while airborne (vy=-JUMP_V), re-armed on landing.
REQ-029 SHALL, with MARIO_DOUBLE_JUMP_EN undefined, ignore jump edges while airborne.

Structure
REQ-030 SHALL take state codes, board bounds, sprite width 34 and height 36 from shared package mario_pkg, which is also used by the renderers.
REQ-031 SHALL implement vertical integration (vy, posY, ceiling and ground clamp) in sub-module mario_vphys.

Verification
REQ-032 SHALL cover: reset, then tick with btn_right -> state STANDING, then WALKING on the next tick with posX=102.
REQ-033 SHALL cover: btn_left held 40 ticks from posX=100 -> posX=50, state CLAMPING, and no underflow.
REQ-034 SHALL cover: jump edge at the ground -> posY 382, 371, 361..., JUMPING until vy=0, then FLYING, then landing at posY=394 and STANDING.
REQ-035 SHALL cover: hit pulse mid-jump -> DYING, position frozen for 32 ticks, then INITIAL at (100,394).
REQ-036 SHALL cover: rst_n low between ticks during FLYING -> outputs become INITIAL, 100, 394 immediately without waiting for a clock.
REQ-037 SHALL cover: second jump edge while airborne -> vy reset to -12 with MARIO_DOUBLE_JUMP_EN, and no effect without it.
